// File: rtl/axp_mul_pkg.sv
// Shared definitions for the AXP opcode-13 iterative multiplier:
// function codes, FSM encoding and the iteration-count helper.
package axp_mul_pkg;

    localparam logic [6:0] FN_MULL   = 7'h00;
    localparam logic [6:0] FN_MULQ   = 7'h20;
    localparam logic [6:0] FN_UMULH  = 7'h30;
    localparam logic [6:0] FN_MULL_V = 7'h40;
    localparam logic [6:0] FN_MULQ_V = 7'h60;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic logic fn_legal(input logic [6:0] f);
        return (f == FN_MULL) || (f == FN_MULQ) || (f == FN_UMULH) ||
               (f == FN_MULL_V) || (f == FN_MULQ_V);
    endfunction

    // Number of RUN cycles: quad forms retire 64 multiplier bits, long forms 32.
    function automatic logic [6:0] iter_count(input int unsigned radix, input logic quad);
        return quad ? 7'(64 / radix) : 7'(32 / radix);
    endfunction

endpackage

// File: rtl/axp_mul_step.sv
// One radix step: adds multiplicand x digit into the 128-bit accumulator
// at the given bit position (unsigned, modulo 2^128).
module axp_mul_step
    import axp_mul_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 4
) (
    input  logic [63:0]           mcand_i,
    input  logic [RADIX_BITS-1:0] digit_i,
    input  logic [127:0]          acc_i,
    input  logic [5:0]            pos_i,
    output logic [127:0]          acc_o
);

    logic [127:0] pp;

    assign pp    = 128'(mcand_i) * 128'(digit_i);
    assign acc_o = acc_i + (pp << pos_i);

endmodule

// File: rtl/axp_mul_iter.sv
// Iterative multiplier for AXP opcode 13 (MULL, MULQ, UMULH, MULL/V, MULQ/V).
// Unsigned radix-2^RADIX_BITS accumulation followed by a one-cycle signed fix-up.
module axp_mul_iter
    import axp_mul_pkg::*;
#(
    parameter int unsigned RADIX_BITS = 4,
    parameter int unsigned TAG_BITS   = 6
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                kill,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [31:0]         cmd,
    input  logic [63:0]         a,
    input  logic [63:0]         b,
    input  logic [TAG_BITS-1:0] tag_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [63:0]         y,
    output logic                ovf,
    output logic                ill,
    output logic [TAG_BITS-1:0] tag_out
);

    state_e                state_q;
    logic                  quad_q, high_q, vchk_q;
    logic [63:0]           mcand_q, mplier_q;
    logic [127:0]          acc_q, acc_d;
    logic [5:0]            it_q, last_q;
    logic [63:0]           y_q;
    logic                  ovf_q, ill_q;
    logic [TAG_BITS-1:0]   tag_q;

    logic [6:0]            fn;
    logic                  accept;
    logic [5:0]            pos;
    logic [63:0]           mshift;
    logic [63:0]           p_long, sh, fix_y;
    logic                  fix_ovf;
    logic                  unused_bits;

    assign fn          = cmd[11:5];
    assign in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept      = in_valid & in_ready & ~kill;
    assign unused_bits = ^{cmd[31:12], cmd[4:0], mshift[63:RADIX_BITS]};

    // Multiplier is kept whole (needed again in FIX); the digit is selected by position.
    assign pos    = 6'(32'(it_q) * RADIX_BITS);
    assign mshift = mplier_q >> pos;

    axp_mul_step #(.RADIX_BITS(RADIX_BITS)) u_step (
        .mcand_i (mcand_q),
        .digit_i (mshift[RADIX_BITS-1:0]),
        .acc_i   (acc_q),
        .pos_i   (pos),
        .acc_o   (acc_d)
    );

    // Long: undo the zero-extension of b. Quad: convert unsigned high word to signed.
    always_comb begin
        p_long  = acc_q[63:0] - (mplier_q[31] ? (mcand_q << 32) : 64'd0);
        sh      = acc_q[127:64] - (mcand_q[63] ? mplier_q : 64'd0)
                                - (mplier_q[63] ? mcand_q : 64'd0);
        fix_y   = acc_q[63:0];
        fix_ovf = 1'b0;
        if (!quad_q) begin
            fix_y   = {{32{p_long[31]}}, p_long[31:0]};
            fix_ovf = vchk_q & ~((&p_long[63:31]) | ~(|p_long[63:31]));
        end else if (high_q) begin
            fix_y = acc_q[127:64];
        end else begin
            fix_ovf = vchk_q & (sh != {64{acc_q[63]}});
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            quad_q   <= 1'b0;
            high_q   <= 1'b0;
            vchk_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            it_q     <= '0;
            last_q   <= '0;
            y_q      <= '0;
            ovf_q    <= 1'b0;
            ill_q    <= 1'b0;
            tag_q    <= '0;
        end else if (kill) begin
            state_q <= ST_IDLE;
        end else if (accept) begin
            tag_q    <= tag_in;
            quad_q   <= fn[5];
            high_q   <= fn[4];
            vchk_q   <= fn[6];
            mcand_q  <= fn[5] ? a : {{32{a[31]}}, a[31:0]};
            mplier_q <= fn[5] ? b : {32'd0, b[31:0]};
            acc_q    <= '0;
            it_q     <= '0;
            last_q   <= 6'(iter_count(RADIX_BITS, fn[5]) - 7'd1);
            if (fn_legal(fn)) begin
                state_q <= ST_RUN;
            end else begin
                state_q <= ST_DONE;
                y_q     <= '0;
                ovf_q   <= 1'b0;
                ill_q   <= 1'b1;
            end
        end else begin
            case (state_q)
                ST_RUN: begin
                    acc_q <= acc_d;
                    it_q  <= it_q + 6'd1;
                    if (it_q == last_q) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    y_q     <= fix_y;
                    ovf_q   <= fix_ovf;
                    ill_q   <= 1'b0;
                    state_q <= ST_DONE;
                end
                ST_DONE: if (out_ready) state_q <= ST_IDLE;
                default: ;
            endcase
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign ovf       = ovf_q;
    assign ill       = ill_q;
    assign tag_out   = tag_q;

endmodule

// File: tb/tb_axp_mul_iter.sv
// Directed bench for axp_mul_iter (RADIX_BITS=4) plus a radix sweep {1,8,32}
// checked against a signed/unsigned 128-bit reference.
module tb_axp_mul_iter;
    import axp_mul_pkg::*;

    localparam int NSW = 3;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        kill = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] cmd = '0;
    logic [63:0] a = '0, b = '0;
    logic [5:0]  tag_in = '0;
    logic        in_ready, out_valid, ovf, ill;
    logic [63:0] y;
    logic [5:0]  tag_out;

    logic             sw_valid = 1'b0, sw_rdy = 1'b0;
    logic [31:0]      sw_cmd = '0;
    logic [63:0]      sw_a = '0, sw_b = '0;
    logic [NSW-1:0]   sw_ir, sw_ov, sw_ovf, sw_ill;
    logic [63:0]      sw_y [NSW];
    logic [5:0]       sw_tag [NSW];

    int n_checks = 0;
    int n_pass = 0;

    always #5 clock = ~clock;

    axp_mul_iter #(.RADIX_BITS(4), .TAG_BITS(6)) u_dut (
        .clock(clock), .reset_n(reset_n), .kill(kill), .in_valid(in_valid),
        .in_ready(in_ready), .cmd(cmd), .a(a), .b(b), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .ovf(ovf),
        .ill(ill), .tag_out(tag_out)
    );

    for (genvar gi = 0; gi < NSW; gi++) begin : g_sw
        axp_mul_iter #(.RADIX_BITS(gi == 0 ? 1 : (gi == 1 ? 8 : 32)), .TAG_BITS(6)) u_sw (
            .clock(clock), .reset_n(reset_n), .kill(1'b0), .in_valid(sw_valid),
            .in_ready(sw_ir[gi]), .cmd(sw_cmd), .a(sw_a), .b(sw_b), .tag_in(6'(gi)),
            .out_valid(sw_ov[gi]), .out_ready(sw_rdy), .y(sw_y[gi]), .ovf(sw_ovf[gi]),
            .ill(sw_ill[gi]), .tag_out(sw_tag[gi])
        );
    end

    function automatic logic [31:0] mk_cmd(input logic [6:0] f);
        return {6'h13, 14'h0, f, 5'h0};
    endfunction

    function automatic void model(input logic [6:0] f, input logic [63:0] av, input logic [63:0] bv,
                                  output logic [63:0] ey, output logic eo);
        logic signed [127:0] sq;
        logic [127:0]        uq;
        logic signed [63:0]  sl;
        ey = '0;
        eo = 1'b0;
        if (f[5] && f[4]) begin
            uq = {64'd0, av} * {64'd0, bv};
            ey = uq[127:64];
        end else if (f[5]) begin
            sq = $signed({{64{av[63]}}, av}) * $signed({{64{bv[63]}}, bv});
            ey = sq[63:0];
            eo = f[6] && (sq[127:63] != {65{sq[63]}});
        end else begin
            sl = $signed({{32{av[31]}}, av[31:0]}) * $signed({{32{bv[31]}}, bv[31:0]});
            ey = {{32{sl[31]}}, sl[31:0]};
            eo = f[6] && (sl[63:31] != {33{sl[31]}});
        end
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one operation; after the accepting edge, scramble the inputs.
    task automatic issue(input logic [6:0] f, input logic [63:0] av, input logic [63:0] bv,
                         input logic [5:0] t);
        cmd = mk_cmd(f); a = av; b = bv; tag_in = t; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; cmd = mk_cmd(7'h01); a = ~av; b = ~bv; tag_in = ~t;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic check_op(input string nm, input logic [6:0] f, input logic [63:0] av,
                            input logic [63:0] bv, input logic [5:0] t, input int exp_lat,
                            input logic [63:0] exp_y, input logic exp_ovf);
        int lat;
        issue(f, av, bv, t);
        wait_valid(lat);
        n_checks++;
        if (lat !== exp_lat) $display("FAIL %s_lat: got %0d want %0d", nm, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (y !== exp_y) $display("FAIL %s_y: got %h want %h", nm, y, exp_y);
        else n_pass++;
        n_checks++;
        if (ovf !== exp_ovf) $display("FAIL %s_ovf: got %b want %b", nm, ovf, exp_ovf);
        else n_pass++;
        n_checks++;
        if (ill !== 1'b0) $display("FAIL %s_ill: got %b want 0", nm, ill);
        else n_pass++;
        n_checks++;
        if (tag_out !== t) $display("FAIL %s_tag: got %0d want %0d", nm, tag_out, t);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset();
        tick();
        tick();
        n_checks++;
        if ({out_valid, ovf, ill} !== 3'b000) $display("FAIL rst_flags: got %b want 000", {out_valid, ovf, ill});
        else n_pass++;
        n_checks++;
        if (y !== 64'd0 || tag_out !== 6'd0) $display("FAIL rst_y_tag: got %h/%0d want 0/0", y, tag_out);
        else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready);
        else n_pass++;
        tick();
    endtask

    task automatic test_quad();
        check_op("mulq", FN_MULQ, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd1, 17, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_op("umulh", FN_UMULH, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd2, 17,
                 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        check_op("mulqv_m1", FN_MULQ_V, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 6'd3, 17,
                 64'd1, 1'b0);
        check_op("mulqv_ovf", FN_MULQ_V, 64'h4000_0000_0000_0000, 64'h4000_0000_0000_0000, 6'd4, 17,
                 64'd0, 1'b1);
        check_op("mulqv_neg", FN_MULQ_V, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 6'd5, 17,
                 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
    endtask

    task automatic test_long();
        check_op("mullv", FN_MULL_V, 64'h7FFF_FFFF, 64'd2, 6'd7, 9, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
        check_op("mull_m1", FN_MULL, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 6'd8, 9, 64'd1, 1'b0);
        check_op("mull_hi", FN_MULL, 64'hDEAD_BEEF_0000_0003, 64'h1234_5678_FFFF_FFFE, 6'd9, 9,
                 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    endtask

    // Illegal codes complete in the cycle right after the accepting edge.
    task automatic test_illegal();
        issue(7'h01, 64'd3, 64'd3, 6'd9);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL ill_valid: got %b want 1", out_valid);
        else n_pass++;
        n_checks++;
        if ({ill, ovf} !== 2'b10) $display("FAIL ill_flags: got %b want 10", {ill, ovf});
        else n_pass++;
        n_checks++;
        if (y !== 64'd0 || tag_out !== 6'd9) $display("FAIL ill_y_tag: got %h/%0d want 0/9", y, tag_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        int lat;
        out_ready = 1'b0;
        issue(FN_MULQ, 64'd3, 64'd5, 6'd5);
        wait_valid(lat);
        n_checks++;
        if (lat !== 17) $display("FAIL b2b_lat1: got %0d want 17", lat);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (y !== 64'd15 || tag_out !== 6'd5) $display("FAIL b2b_hold%0d: got %h/%0d want f/5", i, y, tag_out);
            else n_pass++;
            n_checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0)
                $display("FAIL b2b_hs%0d: got v=%b r=%b want v=1 r=0", i, out_valid, in_ready);
            else n_pass++;
            tick();
        end
        cmd = mk_cmd(FN_MULQ); a = 64'd7; b = 64'd9; tag_in = 6'd6; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL b2b_ready: got %b want 1", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0; a = '0; b = '0;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drop: got %b want 0", out_valid);
        else n_pass++;
        wait_valid(lat);
        n_checks++;
        if (lat !== 17) $display("FAIL b2b_lat2: got %0d want 17", lat);
        else n_pass++;
        n_checks++;
        if (y !== 64'd63 || tag_out !== 6'd6) $display("FAIL b2b_res2: got %h/%0d want 3f/6", y, tag_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_kill();
        int cnt;
        issue(FN_MULQ, 64'd1, 64'd1, 6'd11);
        tick();
        tick();
        kill = 1'b1; cmd = mk_cmd(FN_MULL); a = 64'd2; b = 64'd3; tag_in = 6'd12; in_valid = 1'b1;
        tick();
        kill = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL kill_state: got r=%b v=%b want r=1 v=0", in_ready, out_valid);
        else n_pass++;
        cnt = 0;
        repeat (24) begin
            if (out_valid) cnt++;
            tick();
        end
        n_checks++;
        if (cnt !== 0) $display("FAIL kill_noresult: got %0d valid cycles want 0", cnt);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        int cnt;
        int lat;
        issue(FN_MULQ, 64'd3, 64'd3, 6'd13);
        repeat (5) tick();
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || tag_out !== 6'd0)
            $display("FAIL arst_run: got v=%b tag=%0d want 0/0", out_valid, tag_out);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        cnt = 0;
        repeat (24) begin
            if (out_valid) cnt++;
            tick();
        end
        n_checks++;
        if (cnt !== 0) $display("FAIL arst_noresult: got %0d valid cycles want 0", cnt);
        else n_pass++;
        out_ready = 1'b0;
        issue(FN_MULQ, 64'd3, 64'd3, 6'd14);
        wait_valid(lat);
        n_checks++;
        if (y !== 64'd9) $display("FAIL arst_pre: got %h want 9", y);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || y !== 64'd0) $display("FAIL arst_done: got v=%b y=%h want 0/0", out_valid, y);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_sweep();
        logic [6:0]  fl [5];
        logic [6:0]  f;
        logic [63:0] av, bv, ey;
        logic        eo;
        int          lat [NSW];
        int          cyc, r, elat;
        fl[0] = FN_MULL; fl[1] = FN_MULQ; fl[2] = FN_UMULH; fl[3] = FN_MULL_V; fl[4] = FN_MULQ_V;
        for (int k = 0; k < 12; k++) begin
            f  = fl[k % 5];
            av = {$urandom(), $urandom()};
            bv = {$urandom(), $urandom()};
            if (k == 6) begin av = 64'h8000_0000_0000_0000; bv = '1; end
            if (k == 8) begin av = 64'h8000_0000; bv = 64'hFFFF_FFFF; end
            if (k == 9) begin av = 64'h8000_0000_0000_0000; bv = '1; end
            model(f, av, bv, ey, eo);
            sw_cmd = mk_cmd(f); sw_a = av; sw_b = bv; sw_valid = 1'b1; sw_rdy = 1'b0;
            tick();
            sw_valid = 1'b0; sw_a = ~av; sw_b = ~bv;
            for (int i = 0; i < NSW; i++) lat[i] = 0;
            cyc = 0;
            while (cyc < 100 && !(&sw_ov)) begin
                tick();
                cyc++;
                for (int i = 0; i < NSW; i++) if (sw_ov[i] && lat[i] == 0) lat[i] = cyc;
            end
            for (int i = 0; i < NSW; i++) begin
                r    = (i == 0) ? 1 : ((i == 1) ? 8 : 32);
                elat = (f[5] ? 64 : 32) / r + 1;
                n_checks++;
                if (lat[i] !== elat) $display("FAIL sw%0d_r%0d_lat: got %0d want %0d", k, r, lat[i], elat);
                else n_pass++;
                n_checks++;
                if (sw_y[i] !== ey) $display("FAIL sw%0d_r%0d_y: got %h want %h", k, r, sw_y[i], ey);
                else n_pass++;
                n_checks++;
                if (sw_ovf[i] !== eo) $display("FAIL sw%0d_r%0d_ovf: got %b want %b", k, r, sw_ovf[i], eo);
                else n_pass++;
            end
            sw_rdy = 1'b1;
            tick();
            sw_rdy = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_quad();
        test_long();
        test_illegal();
        test_back_to_back();
        test_kill();
        test_async_reset();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axp_mul_iter.md
Name: axp_mul_iter

Overview:
- Iterative integer multiplier for AXP opcode 13: MULL, MULQ, UMULH, MULL/V, MULQ/V.
- Sits beside the single-cycle opcode 10/11/12 units in the integer execute stage and decodes cmd[11:5] the same way they do.
- Consumes RADIX_BITS multiplier bits per clock behind valid/ready handshakes, and carries an issue tag so the pipeline can match results to instructions.
- Long forms finish in half the iterations of quad forms.

Parameters:
- RADIX_BITS, 4: multiplier bits retired per RUN cycle. Legal values are 1, 2, 4, 8, 16 and 32; each must divide 32.
- TAG_BITS, 6: width of the opaque issue tag.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- kill  in  1  flush: abort any operation held in the block
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept this cycle
- cmd  in  32  instruction word; function is cmd[11:5]
- a  in  64  Ra operand
- b  in  64  Rb operand, or literal already expanded upstream
- tag_in  in  TAG_BITS  issue tag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes the result
- y  out  64  result
- ovf  out  1  integer overflow (/V forms only)
- ill  out  1  unrecognised function code
- tag_out  out  TAG_BITS  tag of the result

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; out_valid=0, y=0, ovf=0, ill=0, tag_out=0. in_ready=1 once reset is released.
- Function decode:
  - 00 = MULL, 20 = MULQ, 30 = UMULH, 40 = MULL/V, 60 = MULQ/V.
  - f[5] selects quad, f[4] selects high half, f[6] enables the overflow check.
  - Any other code is illegal.
- States: IDLE, RUN, FIX, DONE.
- in_ready = IDLE, or (DONE and out_ready). Acceptance = in_valid & in_ready & ~kill.
- On acceptance:
  - Latch tag_in and the function.
  - Multiplicand: a for quad; sext32(a[31:0]) for long.
  - Multiplier: b for quad; b[31:0] zero-extended for long.
  - Clear the 128-bit accumulator.
  - Set the iteration count N: 64/RADIX_BITS for quad, 32/RADIX_BITS for long.
  - Go to RUN. An illegal code goes directly to DONE with y=0, ill=1, ovf=0.
- RUN:
  - Each cycle, add multiplicand × (next RADIX_BITS multiplier bits, LSB first) into the accumulator at the running bit position.
  - Arithmetic is unsigned and modulo 2^128.
  - After N cycles, go to FIX.
- FIX (1 cycle):
  - Long:
    - Subtract (multiplicand<<32) from the accumulator if b[31]=1, giving the exact signed product P.
    - y = sext32(P[31:0]).
    - ovf = f[6] & (P[63:31] not all equal).
  - Quad, unsigned high word H = acc[127:64]:
    - Signed high word SH = H − (a[63]?b:0) − (b[63]?a:0), computed mod 2^64.
    - MULQ: y = acc[63:0]; ovf = f[6] & (SH ≠ {64{acc[63]}}).
    - UMULH: y = H; ovf = 0.
  - Go to DONE.
- DONE:
  - out_valid=1; y, ovf, ill and tag_out are held stable while out_ready=0.
  - out_ready=1 with no new acceptance: go to IDLE. With a same-cycle acceptance: go to RUN.
- Latency from the accepting edge to the first cycle with out_valid high: N+1 clocks.
  - RADIX_BITS=4: MULQ/UMULH 17, MULL 9.
  - RADIX_BITS=32: quad 3, long 2.
  - Illegal code: 1.
- kill, in any state:
  - Next state is IDLE and out_valid drops the next cycle.
  - A result in DONE is discarded even if out_ready is high in the same cycle.
  - kill takes priority over in_valid.
- Operand ports and cmd are sampled only at acceptance; later changes on them have no effect on the operation in flight.
- The /V forms only report the overflow. Trap generation is the consumer's job.
- y is don't-care when out_valid=0, but it must not change while DONE is held.

Decomposition:
- Package axp_mul_pkg holds:
  - the function-code constants (MULL, MULQ, UMULH, MULL_V, MULQ_V);
  - the state encoding;
  - the iteration-count function of RADIX_BITS and quad/long.
- One sub-module, axp_mul_step: combinational, with ports (multiplicand 64, digit RADIX_BITS, acc 128, position) → acc'. It is instantiated once; the FSM wraps it.

Test Plan:
- MULQ, a=0xFFFFFFFFFFFFFFFF, b=2 → y=0xFFFFFFFFFFFFFFFE, ovf=0; out_valid exactly 17 clocks after acceptance (RADIX_BITS=4).
- UMULH, a=b=0xFFFFFFFFFFFFFFFF → y=0xFFFFFFFFFFFFFFFE. MULQ/V with the same operands → y=1, ovf=0. MULQ/V with a=b=0x4000000000000000 → y=0, ovf=1.
- MULL/V, a=0x7FFFFFFF, b=2 → y=0xFFFFFFFFFFFFFFFE, ovf=1; latency 9. MULL, a=0xFFFFFFFF, b=0xFFFFFFFF (−1×−1) → y=1, ovf=0.
- Back-to-back with handshakes:
  - Two MULQs with tags 5 and 6, out_ready held low for 4 cycles on the first result → y/tag_out stay stable.
  - The second operation is accepted in the same cycle out_ready rises; the tags come out in order.
- kill during RUN (cycle 3 of a MULQ), with a new MULL on in_valid in the same cycle → MULL not accepted, in_ready=1 the next cycle, no out_valid for the killed operation. Assert reset_n low mid-RUN → out_valid=0 immediately (asynchronously).
- Illegal function 0x01 → out_valid after 1 clock, ill=1, y=0. Sweep RADIX_BITS over {1, 8, 32} with random operands checked against a 128-bit reference model.
